// File: rtl/dl_report_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dl_report_responder_if
// Brief    : Status-record valid/ready handshake of the deadlock report unit.
// Revision : 1.0 - initial release
// ============================================================================
interface dl_report_responder_if #(
    parameter int IDX_W = 1,
    parameter int CNT_W = 16
);
    logic             report_valid;
    logic             report_ready;
    logic [IDX_W-1:0] report_origin_idx;
    logic [CNT_W-1:0] report_inflight;

    modport master (
        output report_valid,
        output report_origin_idx,
        output report_inflight,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_origin_idx,
        input  report_inflight,
        output report_ready
    );
endinterface
`default_nettype wire

// File: rtl/dl_report_responder.sv
`default_nettype none
// ============================================================================
// Module   : dl_report_responder
// Brief    : Debounces the deadlock ring flags, elects an origin process and
//            emits one status record before re-arming the ring.
// Revision : 1.0 - initial release
// ============================================================================
module dl_report_responder #(
    parameter int PROC_NUM       = 2,
    parameter int CNT_W          = 16,
    parameter int CONFIRM_CYCLES = 4,
    parameter int IDX_W          = 1
) (
    input  logic                dl_clock,
    input  logic                dl_reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic                all_finish,
    input  logic [CNT_W-1:0]    trans_in_cnt_0,
    input  logic [CNT_W-1:0]    trans_out_cnt_0,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic [7:0]          dl_count,
    dl_report_responder_if.master rpt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    localparam logic [7:0] CONFIRM_LAST = 8'(CONFIRM_CYCLES);

    logic [1:0]          state_q,    state_d;
    logic [7:0]          cnt_q,      cnt_d;
    logic [IDX_W-1:0]    sel_q,      sel_d;
    logic [PROC_NUM-1:0] origin_q,   origin_d;
    logic                detect_q,   detect_d;
    logic                token_q,    token_d;
    logic                valid_q,    valid_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [7:0]          count_q,    count_d;

    logic [IDX_W-1:0]    lowest_idx;
    logic                sel_flag;
    logic                to_idle;

    // Scanning from the top down leaves the lowest set bit as the winner.
    always_comb begin
        lowest_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_in_vec[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // origin_q is one-hot of sel_q while confirming, so this picks the elected flag.
    assign sel_flag = |(dl_in_vec & origin_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        origin_d   = origin_q;
        detect_d   = detect_q;
        token_d    = token_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        to_idle    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((|dl_in_vec) && !all_finish) begin
                    state_d  = S_CONFIRM;
                    sel_d    = lowest_idx;
                    origin_d = PROC_NUM'(1) << lowest_idx;
                    cnt_d    = 8'd1;
                end
            end
            S_CONFIRM: begin
                if (all_finish || !sel_flag) begin
                    to_idle = 1'b1;
                end else if (cnt_q == CONFIRM_LAST) begin
                    state_d    = S_REPORT;
                    detect_d   = 1'b1;
                    valid_d    = 1'b1;
                    idx_d      = sel_q;
                    inflight_d = trans_in_cnt_0 - trans_out_cnt_0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_REPORT: begin
                // An abort outranks a same-cycle acceptance: the record is dropped.
                if (all_finish) begin
                    to_idle = 1'b1;
                end else if (valid_q && rpt.report_ready) begin
                    state_d = S_CLEAR;
                    valid_d = 1'b0;
                    token_d = 1'b1;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            S_CLEAR: begin
                to_idle = 1'b1;
            end
            default: begin
                to_idle = 1'b1;
            end
        endcase

        if (to_idle) begin
            state_d    = S_IDLE;
            cnt_d      = 8'd0;
            sel_d      = '0;
            origin_d   = '0;
            detect_d   = 1'b0;
            token_d    = 1'b0;
            valid_d    = 1'b0;
            idx_d      = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge dl_clock) begin
        if (!dl_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            sel_q      <= '0;
            origin_q   <= '0;
            detect_q   <= 1'b0;
            token_q    <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            inflight_q <= '0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            origin_q   <= origin_d;
            detect_q   <= detect_d;
            token_q    <= token_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    assign dl_detect_out         = detect_q;
    assign origin                = origin_q;
    assign token_clear           = token_q;
    assign dl_count              = count_q;
    assign rpt.report_valid      = valid_q;
    assign rpt.report_origin_idx = idx_q;
    assign rpt.report_inflight   = inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_report_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dl_report_responder
// Brief    : Self-checking bench: vector table, corner sequences and random
//            stimulus against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dl_report_responder;

    localparam int PROC_NUM = 2;
    localparam int CNT_W    = 16;
    localparam int CONFIRM  = 4;
    localparam int IDX_W    = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [PROC_NUM-1:0] vec;
    logic                af;
    logic [CNT_W-1:0]    cin, cout;
    logic                det, tok;
    logic [PROC_NUM-1:0] org;
    logic [7:0]          dcount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dl_report_responder_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) rif ();

    dl_report_responder #(
        .PROC_NUM       (PROC_NUM),
        .CNT_W          (CNT_W),
        .CONFIRM_CYCLES (CONFIRM),
        .IDX_W          (IDX_W)
    ) dut (
        .dl_clock        (clk),
        .dl_reset        (rst_n),
        .dl_in_vec       (vec),
        .all_finish      (af),
        .trans_in_cnt_0  (cin),
        .trans_out_cnt_0 (cout),
        .dl_detect_out   (det),
        .origin          (org),
        .token_clear     (tok),
        .dl_count        (dcount),
        .rpt             (rif)
    );

    // Behavioural model: phase 0 idle, 1 debouncing, 2 record offered, 3 re-arm.
    int m_phase = 0, m_sel = 0, m_run = 0, m_cnt = 0, m_inf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0; m_sel = 0; m_run = 0; m_cnt = 0; m_inf = 0;
        end else begin
            case (m_phase)
                0: if (vec != 0 && !af) begin
                    for (int i = PROC_NUM - 1; i >= 0; i--) if (vec[i]) m_sel = i;
                    m_run   = 1;
                    m_phase = 1;
                end
                1: if (af || !vec[m_sel]) begin
                    m_phase = 0;
                end else begin
                    m_run++;
                    if (m_run > CONFIRM) begin
                        m_phase = 2;
                        m_inf   = (int'(cin) - int'(cout) + (1 << CNT_W)) % (1 << CNT_W);
                    end
                end
                2: if (af) begin
                    m_phase = 0;
                end else if (rif.report_ready) begin
                    m_phase = 3;
                    if (m_cnt < 255) m_cnt++;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic model_cmp();
        logic [PROC_NUM-1:0] e_org;
        e_org = (m_phase != 0) ? PROC_NUM'(1 << m_sel) : '0;
        chk("m_detect", 32'(det), 32'(m_phase >= 2));
        chk("m_origin", 32'(org), 32'(e_org));
        chk("m_token",  32'(tok), 32'(m_phase == 3));
        chk("m_valid",  32'(rif.report_valid), 32'(m_phase == 2));
        chk("m_count",  32'(dcount), 32'(m_cnt));
        if (m_phase == 2) begin
            chk("m_idx",      32'(rif.report_origin_idx), 32'(m_sel));
            chk("m_inflight", 32'(rif.report_inflight), 32'(m_inf));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_cmp();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rif.report_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(rif.report_valid), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  vec;
        logic        af;
        logic        rdy;
        logic [15:0] cin;
        logic [15:0] cout;
        logic        e_det;
        logic [1:0]  e_org;
        logic        e_tok;
        logic        e_val;
        logic        e_idx;
        logic [15:0] e_inf;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic detection, glitch rejection and re-election after a dropped flag.
        tbl[0]  = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b10, 0, 0, 0, 16'd0, 8'd0};
        tbl[1]  = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b10, 0, 0, 0, 16'd0, 8'd0};
        tbl[2]  = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b10, 0, 0, 0, 16'd0, 8'd0};
        tbl[3]  = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b10, 0, 0, 0, 16'd0, 8'd0};
        tbl[4]  = '{2'b10, 0, 1, 16'd5, 16'd3, 1, 2'b10, 0, 1, 1, 16'd2, 8'd0};
        tbl[5]  = '{2'b10, 0, 1, 16'd5, 16'd3, 1, 2'b10, 1, 0, 0, 16'd0, 8'd1};
        tbl[6]  = '{2'b00, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};
        tbl[7]  = '{2'b00, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};
        tbl[8]  = '{2'b01, 0, 1, 16'd5, 16'd3, 0, 2'b01, 0, 0, 0, 16'd0, 8'd1};
        tbl[9]  = '{2'b01, 0, 1, 16'd5, 16'd3, 0, 2'b01, 0, 0, 0, 16'd0, 8'd1};
        tbl[10] = '{2'b01, 0, 1, 16'd5, 16'd3, 0, 2'b01, 0, 0, 0, 16'd0, 8'd1};
        tbl[11] = '{2'b00, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};
        tbl[12] = '{2'b00, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};
        tbl[13] = '{2'b11, 0, 1, 16'd5, 16'd3, 0, 2'b01, 0, 0, 0, 16'd0, 8'd1};
        tbl[14] = '{2'b11, 0, 1, 16'd5, 16'd3, 0, 2'b01, 0, 0, 0, 16'd0, 8'd1};
        tbl[15] = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};
        tbl[16] = '{2'b10, 0, 1, 16'd5, 16'd3, 0, 2'b10, 0, 0, 0, 16'd0, 8'd1};
        tbl[17] = '{2'b00, 0, 1, 16'd5, 16'd3, 0, 2'b00, 0, 0, 0, 16'd0, 8'd1};

        rst_n = 1'b0; vec = '0; af = 1'b0; cin = '0; cout = '0; rif.report_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_outputs", {det, org, tok, rif.report_valid, rif.report_origin_idx, rif.report_inflight, dcount}, 32'd0);

        repeat (20) tick();
        chk("idle_outputs", {det, org, tok, rif.report_valid, rif.report_origin_idx, rif.report_inflight, dcount}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            vec = tbl[i].vec; af = tbl[i].af; rif.report_ready = tbl[i].rdy;
            cin = tbl[i].cin; cout = tbl[i].cout;
            tick();
            chk($sformatf("tbl%0d_det", i),   32'(det),    32'(tbl[i].e_det));
            chk($sformatf("tbl%0d_org", i),   32'(org),    32'(tbl[i].e_org));
            chk($sformatf("tbl%0d_tok", i),   32'(tok),    32'(tbl[i].e_tok));
            chk($sformatf("tbl%0d_val", i),   32'(rif.report_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_cnt", i),   32'(dcount), 32'(tbl[i].e_cnt));
            if (tbl[i].e_val) begin
                chk($sformatf("tbl%0d_idx", i), 32'(rif.report_origin_idx), 32'(tbl[i].e_idx));
                chk($sformatf("tbl%0d_inf", i), 32'(rif.report_inflight),   32'(tbl[i].e_inf));
            end
        end

        // Backpressure: record must stay frozen while the counters move underneath.
        rif.report_ready = 1'b0; vec = 2'b10; cin = 16'd100; cout = 16'd40;
        wait_valid("bp_reach_report");
        cin = 16'd7; cout = 16'd9;
        repeat (10) begin
            tick();
            chk("bp_valid",    32'(rif.report_valid),      32'd1);
            chk("bp_idx",      32'(rif.report_origin_idx), 32'd1);
            chk("bp_inflight", 32'(rif.report_inflight),   32'd60);
            chk("bp_no_token", 32'(tok),                   32'd0);
        end
        rif.report_ready = 1'b1; vec = 2'b00;
        tick();
        chk("bp_token",  32'(tok),    32'd1);
        chk("bp_count",  32'(dcount), 32'd2);
        tick();
        chk("bp_token_single", 32'(tok), 32'd0);

        // Abort in REPORT with ready also high: abort wins, nothing counted.
        rif.report_ready = 1'b0; vec = 2'b10;
        wait_valid("abort_reach_report");
        af = 1'b1; rif.report_ready = 1'b1; vec = 2'b00;
        tick();
        chk("abort_outputs", {det, org, tok, rif.report_valid}, 32'd0);
        chk("abort_count",   32'(dcount), 32'd2);
        af = 1'b0; rif.report_ready = 1'b0;
        tick();
        chk("abort_no_token", 32'(tok), 32'd0);

        // Abort while in CLEAR: the re-arm pulse completes and the count holds.
        vec = 2'b10;
        wait_valid("clear_reach_report");
        rif.report_ready = 1'b1; vec = 2'b00;
        tick();
        af = 1'b1;
        chk("clear_af_token", 32'(tok), 32'd1);
        tick();
        chk("clear_af_count", 32'(dcount), 32'd3);
        chk("clear_af_idle",  {det, org, tok}, 32'd0);
        af = 1'b0; rif.report_ready = 1'b0;

        // Counter wrap-around.
        cin = 16'h0001; cout = 16'hFFFF; vec = 2'b01;
        wait_valid("wrap_reach_report");
        chk("wrap_inflight", 32'(rif.report_inflight),   32'h0002);
        chk("wrap_idx",      32'(rif.report_origin_idx), 32'd0);
        rif.report_ready = 1'b1; vec = 2'b00;
        tick();
        chk("wrap_count", 32'(dcount), 32'd4);
        tick();
        rif.report_ready = 1'b0;

        // Reset asserted mid-REPORT clears everything, count included.
        vec = 2'b10;
        wait_valid("rst_reach_report");
        rst_n = 1'b0; rif.report_ready = 1'b1;
        tick();
        chk("midreset_outputs", {det, org, tok, rif.report_valid, rif.report_origin_idx, rif.report_inflight, dcount}, 32'd0);
        rst_n = 1'b1; vec = 2'b00;
        tick();

        // Saturation: continuous flag with ready high yields a report every 7 edges.
        vec = 2'b10; rif.report_ready = 1'b1; cin = 16'd3; cout = 16'd1;
        repeat (1900) tick();
        chk("sat_count", 32'(dcount), 32'd255);
        vec = 2'b00;
        repeat (3) tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) vec = PROC_NUM'($urandom);
            af               = ($urandom_range(0, 31) == 0);
            rif.report_ready = 1'($urandom);
            cin              = CNT_W'($urandom);
            cout             = CNT_W'($urandom);
            rst_n            = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dl_report_responder.md
Name: dl_report_responder

Overview:
- Synthesizable deadlock report unit that terminates the per-process deadlock-detect-unit ring in a dataflow region.
- Consumes the per-process deadlock flags (dl_in_vec) and the start/done transaction counters of process 0.
- Debounces a candidate deadlock, then elects an origin process and broadcasts dl_detect_out to freeze the detect units.
- Emits one status record through a valid/ready handshake, then pulses token_clear to re-arm the ring.

Parameters:
- PROC_NUM, 2: number of dataflow processes; width of dl_in_vec and origin.
- CNT_W, 16: width of the transaction counters and of report_inflight.
- CONFIRM_CYCLES, 4: consecutive cycles the elected process flag must stay high before a deadlock is declared; legal range 1..255.
- IDX_W, 1: width of report_origin_idx; must be at least clog2(PROC_NUM), minimum 1.

Ports:
- dl_clock, in, 1: clock; all logic on the rising edge.
- dl_reset, in, 1: reset, synchronous, active-low.
- dl_in_vec, in, PROC_NUM: per-process deadlock flags, already masked by all_finish upstream.
- all_finish, in, 1: design finished; abort any detection in progress.
- trans_in_cnt_0, in, CNT_W: process 0 start count.
- trans_out_cnt_0, in, CNT_W: process 0 done-and-continue count.
- dl_detect_out, out, 1: deadlock declared; broadcast to all detect units.
- origin, out, PROC_NUM: one-hot origin process for token injection.
- token_clear, out, 1: one-cycle ring re-arm pulse.
- report_valid, out, 1: status record valid.
- report_ready, in, 1: consumer accepts the record.
- report_origin_idx, out, IDX_W: binary index of the origin process.
- report_inflight, out, CNT_W: trans_in_cnt_0 minus trans_out_cnt_0, modulo 2^CNT_W.
- dl_count, out, 8: number of accepted reports, saturating.

Behaviour:
- Reset (dl_reset low at a rising edge): state IDLE; every output 0, including dl_count and the confirm counter. Reset overrides everything, including mid-handshake.
- IDLE: if dl_in_vec is nonzero and all_finish is 0, capture sel = index of the lowest set bit, drive origin = 1<<sel, and go to CONFIRM with cnt=1.
- CONFIRM: origin is held.
  - If dl_in_vec[sel] is 1, cnt increments. Other bits are ignored; sel never changes while in CONFIRM.
  - When the sampled flag is high and cnt equals CONFIRM_CYCLES, go to REPORT. With CONFIRM_CYCLES=1, CONFIRM lasts exactly one cycle.
  - If dl_in_vec[sel] is 0, go to IDLE; origin is 0 next cycle.
- REPORT, on entry:
  - dl_detect_out=1 and report_valid=1.
  - report_origin_idx=sel.
  - report_inflight is latched from the counters on the transition edge and is stable until accepted.
- REPORT, hold: stay until report_valid and report_ready are both 1. On that edge, dl_count increments (saturating at 255) and the state goes to CLEAR.
- CLEAR: one cycle; token_clear=1, dl_detect_out=1, report_valid=0, origin held. Next cycle go to IDLE with dl_detect_out, origin and token_clear all 0.
- IDLE re-detection: a new detection may start the cycle after returning to IDLE.
- all_finish=1 in CONFIRM or REPORT: go to IDLE next cycle with all outputs except dl_count cleared; the report is dropped and dl_count is unchanged.
- all_finish=1 in CLEAR: no effect; CLEAR completes.
- all_finish and report_ready both 1 in REPORT: all_finish wins; no count.
- Latency: first flag-high edge to dl_detect_out high is CONFIRM_CYCLES+1 edges.
- Outputs are registered and state-driven; report_ready has no combinational path to any output.
- Counter wrap-around: inflight = (in - out) mod 2^CNT_W, so in=0x0001 and out=0xFFFF give 0x0002.

Test Plan:
- Reset then idle: dl_in_vec=0 for 20 cycles -> every output stays 0, dl_count=0.
- Basic detection:
  - Stimulus: dl_in_vec=2'b10 held, counters 5/3, report_ready=1.
  - Response: origin=2'b10 one cycle after the first flag-high edge; dl_detect_out=1 five edges after it; report_origin_idx=1, inflight=2; token_clear is a single pulse; dl_count=1.
- Glitch rejection: dl_in_vec=2'b01 for 3 cycles then 0 -> no dl_detect_out; origin returns to 0. Flag 2'b11 with bit0 dropping after 2 cycles -> back to IDLE, then re-elects sel=1 on the next pass.
- Backpressure: report_ready=0 for 10 cycles in REPORT -> valid, idx and inflight stable throughout; token_clear only after the ready edge.
- all_finish abort: assert in REPORT -> IDLE next cycle, no token_clear, dl_count unchanged. Assert in CLEAR -> token_clear still pulses.
- Wrap and saturation: counters 0x0001/0xFFFF -> inflight 0x0002. After 260 accepted reports -> dl_count=255. Reset asserted mid-REPORT -> all outputs 0 next cycle.
